pps_multi_sync: RTL and testbench
=================================

Name: pps_multi_sync

Overview:
Multi-channel PPS synchronizer and monitor for the timing subsystem. Each channel takes an asynchronous PPS input and synchronizes it into the timebase clock domain. It then detects the selected edge and keeps a wrapping edge counter. It also measures the period between edges and qualifies the pulse train against a runtime nominal period and tolerance, flagging lost or out-of-tolerance PPS. VITA time-alignment logic and status registers use its outputs.

Parameters:
NUM_CH, 1, number of independent PPS channels (>=1)
SYNC_STAGES, 2, synchronizer flops per channel (>=2)
CNT_W, 32, period counter / period port width
EDGE_CNT_W, 1, edge counter width; 1 gives the legacy toggle-per-edge behaviour
VALID_CNT, 2, consecutive in-tolerance periods required before pps_valid asserts (>=1)

Ports:
clk  in  1  timebase clock
rst_n  in  1  asynchronous active-low reset
pps_in  in  NUM_CH  asynchronous PPS inputs
falling_edge  in  NUM_CH  per-channel edge select: 0 = rising, 1 = falling; quasi-static
period_nom  in  CNT_W  nominal period in clk cycles; shared by all channels
period_tol  in  CNT_W  allowed +/- deviation in clk cycles
pps_out  out  NUM_CH  synchronized PPS level
pps_pulse  out  NUM_CH  one-cycle strobe per selected edge
pps_count  out  NUM_CH*EDGE_CNT_W  per-channel wrapping edge counter; ch i at [i*EDGE_CNT_W +: EDGE_CNT_W]
period_meas  out  NUM_CH*CNT_W  last measured period, ch i at [i*CNT_W +: CNT_W]
period_err  out  NUM_CH  one-cycle strobe: measured period out of tolerance
pps_lost  out  NUM_CH  level: no edge within period_nom+period_tol
pps_valid  out  NUM_CH  level: pulse train qualified

Behaviour:
- Reset (rst_n low, async): all sync flops, outputs, counters and state clear to 0; every channel enters IDLE.
- Channels are fully independent; the rules below apply per channel.
- Sync chain: pps_out is the last stage of a SYNC_STAGES flop chain clocked by clk. No reset-free stages.
- Edge detect: a registered copy of pps_out. A selected edge (0->1 if falling_edge=0, 1->0 if falling_edge=1) asserts pps_pulse for exactly one cycle, on the cycle after pps_out changes.
- Latency: pps_in change to pps_pulse is SYNC_STAGES+1 cycles, +/-1 cycle for async sampling.
- pps_count increments by 1, wrapping modulo 2^EDGE_CNT_W, in the cycle after each pps_pulse.
- Period counter cnt: loads 1 on a pps_pulse cycle and increments each cycle otherwise. It saturates at all-ones and never wraps.
- Bounds: upper = period_nom + period_tol, computed at CNT_W+1 bits. lower = period_nom - period_tol, floored at 0.
- FSM states:
  - IDLE: on pulse -> MEASURE. period_meas unchanged.
  - MEASURE/TRACK on pulse: period_meas <= cnt.
    - If lower <= cnt <= upper: good_cnt++ (saturating at VALID_CNT). When good_cnt reaches VALID_CNT, state -> TRACK and pps_valid=1.
    - Otherwise: period_err pulses, good_cnt=0, pps_valid=0, state -> MEASURE.
  - MEASURE/TRACK with no pulse and cnt > upper: pps_lost=1, pps_valid=0, good_cnt=0, state -> IDLE.
  - IDLE with pps_lost=1: pps_lost clears on the next pulse. That pulse restarts measurement and produces no compare and no period_err.
- Simultaneous events:
  - A pulse in the same cycle as the timeout condition is handled as a pulse (compare path). pps_lost is not set.
  - If period_tol >= period_nom, lower is 0.
  - If period_nom = 0 and period_tol = 0, every period is an error.
- Output timing: period_err and period_meas update are registered, asserting in the cycle after the pps_pulse cycle.
- Input changes:
  - A period_nom or period_tol change takes effect at the next compare or timeout evaluation.
  - A falling_edge change may produce one spurious pulse; no further guarantee.
- Mid-operation reset clears everything immediately; the first post-reset edge is treated as IDLE.

Test Plan:
- Reset, then drive pps_in ch0 0->1 and hold -> pps_out rises after SYNC_STAGES cycles. Exactly one pps_pulse follows. pps_count = 1; with EDGE_CNT_W=1 it toggles back to 0 on the next edge.
- period_nom=1000, period_tol=10, edges every 1000 cycles, VALID_CNT=2 -> period_meas=1000 after the 2nd edge. pps_valid asserts after the 3rd edge. No period_err.
- Locked, then one edge at 1020 cycles -> period_meas=1020, period_err one cycle, pps_valid=0. Valid regained after 2 good periods.
- Locked, then stop edges -> pps_lost=1 and pps_valid=0 once cnt reaches 1011. The next edge clears pps_lost without a period_err.
- NUM_CH=2, falling_edge=2'b10, independent waveforms -> ch1 pulses on falling edges only. Counts and flags are independent per channel.
- Assert rst_n low mid-TRACK -> all outputs 0 immediately. The first edge after release gives no period_meas update.

Source files
------------

// File: rtl/pps_multi_sync.sv
// Multi-channel PPS synchronizer and monitor: per-channel sync, edge detect, edge counter,
// period measurement and qualification against a runtime nominal period and tolerance.
module pps_multi_sync #(
    parameter int unsigned NUM_CH      = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned EDGE_CNT_W  = 1,
    parameter int unsigned VALID_CNT   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              pps_in,
    input  logic [NUM_CH-1:0]              falling_edge,
    input  logic [CNT_W-1:0]               period_nom,
    input  logic [CNT_W-1:0]               period_tol,
    output logic [NUM_CH-1:0]              pps_out,
    output logic [NUM_CH-1:0]              pps_pulse,
    output logic [NUM_CH*EDGE_CNT_W-1:0]   pps_count,
    output logic [NUM_CH*CNT_W-1:0]        period_meas,
    output logic [NUM_CH-1:0]              period_err,
    output logic [NUM_CH-1:0]              pps_lost,
    output logic [NUM_CH-1:0]              pps_valid
);

    localparam int unsigned GW = $clog2(VALID_CNT + 1);
    localparam logic [GW-1:0] GoodMax = GW'(VALID_CNT);

    typedef enum logic [1:0] {StIdle, StMeasure, StTrack} state_e;

    // Bounds are shared by all channels; upper carries one extra bit so nom+tol cannot wrap.
    logic [CNT_W:0]   upper;
    logic [CNT_W-1:0] lower;

    always_comb begin
        upper = {1'b0, period_nom} + {1'b0, period_tol};
        lower = (period_nom >= period_tol) ? (period_nom - period_tol) : '0;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic                   pulse_q, pulse_d;
        logic [EDGE_CNT_W-1:0]  ecnt_q;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic [CNT_W-1:0]       meas_q, meas_d;
        logic [GW-1:0]          good_q, good_d;
        logic                   err_q, err_d;
        logic                   lost_q, lost_d;
        logic                   valid_q, valid_d;
        state_e                 state_q, state_d;
        logic                   lvl;
        logic                   in_tol;
        logic                   timeout;

        assign lvl = sync_q[SYNC_STAGES-1];

        always_comb begin
            pulse_d = falling_edge[i] ? (prev_q & ~lvl) : (~prev_q & lvl);
            cnt_d   = pulse_q ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
            in_tol  = ({1'b0, cnt_q} <= upper) && (cnt_q >= lower);
            timeout = {1'b0, cnt_q} > upper;
        end

        always_comb begin
            state_d = state_q;
            good_d  = good_q;
            valid_d = valid_q;
            lost_d  = lost_q;
            err_d   = 1'b0;
            meas_d  = meas_q;
            unique case (state_q)
                StIdle: begin
                    // First edge after idle only restarts measurement; nothing to compare yet.
                    if (pulse_q) begin
                        state_d = StMeasure;
                        lost_d  = 1'b0;
                        good_d  = '0;
                    end
                end
                StMeasure, StTrack: begin
                    if (pulse_q) begin
                        meas_d = cnt_q;
                        if (in_tol) begin
                            if (good_q >= GoodMax - GW'(1)) begin
                                good_d  = GoodMax;
                                valid_d = 1'b1;
                                state_d = StTrack;
                            end else begin
                                good_d = good_q + GW'(1);
                            end
                        end else begin
                            err_d   = 1'b1;
                            good_d  = '0;
                            valid_d = 1'b0;
                            state_d = StMeasure;
                        end
                    end else if (timeout) begin
                        lost_d  = 1'b1;
                        valid_d = 1'b0;
                        good_d  = '0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q  <= '0;
                prev_q  <= 1'b0;
                pulse_q <= 1'b0;
                ecnt_q  <= '0;
                cnt_q   <= '0;
                meas_q  <= '0;
                good_q  <= '0;
                err_q   <= 1'b0;
                lost_q  <= 1'b0;
                valid_q <= 1'b0;
                state_q <= StIdle;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], pps_in[i]};
                prev_q  <= lvl;
                pulse_q <= pulse_d;
                if (pulse_q) begin
                    ecnt_q <= ecnt_q + EDGE_CNT_W'(1);
                end
                cnt_q   <= cnt_d;
                meas_q  <= meas_d;
                good_q  <= good_d;
                err_q   <= err_d;
                lost_q  <= lost_d;
                valid_q <= valid_d;
                state_q <= state_d;
            end
        end

        assign pps_out[i]                              = lvl;
        assign pps_pulse[i]                            = pulse_q;
        assign pps_count[i*EDGE_CNT_W +: EDGE_CNT_W]   = ecnt_q;
        assign period_meas[i*CNT_W +: CNT_W]           = meas_q;
        assign period_err[i]                           = err_q;
        assign pps_lost[i]                             = lost_q;
        assign pps_valid[i]                            = valid_q;
    end

endmodule

// File: tb/tb_pps_multi_sync.sv
// Directed bench for pps_multi_sync: two channels (ch1 on falling edges), hand-computed
// pulse/count/period/qualification expectations, immediate assertions at each check.
module tb_pps_multi_sync;

    localparam int unsigned NCH = 2;
    localparam int unsigned SS  = 2;
    localparam int unsigned CW  = 16;
    localparam int unsigned EW  = 2;
    localparam int unsigned VC  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    pps_in;
    logic [NCH-1:0]    falling_edge;
    logic [CW-1:0]     period_nom;
    logic [CW-1:0]     period_tol;
    logic [NCH-1:0]    pps_out;
    logic [NCH-1:0]    pps_pulse;
    logic [NCH*EW-1:0] pps_count;
    logic [NCH*CW-1:0] period_meas;
    logic [NCH-1:0]    period_err;
    logic [NCH-1:0]    pps_lost;
    logic [NCH-1:0]    pps_valid;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [EW-1:0] exp_cnt [NCH];

    pps_multi_sync #(
        .NUM_CH      (NCH),
        .SYNC_STAGES (SS),
        .CNT_W       (CW),
        .EDGE_CNT_W  (EW),
        .VALID_CNT   (VC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pps_in       (pps_in),
        .falling_edge (falling_edge),
        .period_nom   (period_nom),
        .period_tol   (period_tol),
        .pps_out      (pps_out),
        .pps_pulse    (pps_pulse),
        .pps_count    (pps_count),
        .period_meas  (period_meas),
        .period_err   (period_err),
        .pps_lost     (pps_lost),
        .pps_valid    (pps_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One selected edge on channel ch; next selected edge starts gap cycles later (gap >= 6).
    task automatic edge_ch(input int ch, input int gap, input logic exp_err);
        pps_in[ch] = !falling_edge[ch];
        run(SS);
        chk("pps_out follows", 32'(pps_out[ch]), 32'(!falling_edge[ch]));
        chk("no early pulse", 32'(pps_pulse[ch]), 32'd0);
        run(1);
        chk("pulse", 32'(pps_pulse[ch]), 32'd1);
        exp_cnt[ch] = exp_cnt[ch] + 1'b1;
        run(1);
        chk("pulse width", 32'(pps_pulse[ch]), 32'd0);
        chk("edge count", 32'(pps_count[ch*EW +: EW]), 32'(exp_cnt[ch]));
        chk("period_err", 32'(period_err[ch]), 32'(exp_err));
        run(1);
        chk("period_err width", 32'(period_err[ch]), 32'd0);
        pps_in[ch] = falling_edge[ch];
        run(gap - 5);
    endtask

    initial begin
        rst_n        = 1'b0;
        pps_in       = '0;
        falling_edge = 2'b10;
        period_nom   = CW'(1000);
        period_tol   = CW'(10);
        exp_cnt[0]   = '0;
        exp_cnt[1]   = '0;
        run(3);
        chk("reset pps_out", 32'(pps_out), 32'd0);
        chk("reset pulse", 32'(pps_pulse), 32'd0);
        chk("reset count", 32'(pps_count), 32'd0);
        chk("reset meas", period_meas, 32'd0);
        chk("reset flags", 32'({period_err, pps_lost, pps_valid}), 32'd0);
        rst_n = 1'b1;
        run(2);

        // ch0 rising edges: acquire lock at the 3rd edge.
        edge_ch(0, 1000, 1'b0);
        chk("ch0 idle meas", 32'(period_meas[0 +: CW]), 32'd0);
        edge_ch(0, 1000, 1'b0);
        chk("ch0 meas 2nd", 32'(period_meas[0 +: CW]), 32'd1000);
        chk("ch0 not valid yet", 32'(pps_valid[0]), 32'd0);
        edge_ch(0, 1010, 1'b0);
        chk("ch0 valid 3rd", 32'(pps_valid[0]), 32'd1);
        edge_ch(0, 1011, 1'b0);
        chk("ch0 upper inclusive", 32'(period_meas[0 +: CW]), 32'd1010);
        chk("ch0 still valid", 32'(pps_valid[0]), 32'd1);
        // Pulse coincides with cnt > upper: compare path wins, no pps_lost.
        edge_ch(0, 1000, 1'b1);
        chk("ch0 meas 1011", 32'(period_meas[0 +: CW]), 32'd1011);
        chk("ch0 valid dropped", 32'(pps_valid[0]), 32'd0);
        chk("ch0 no lost on tie", 32'(pps_lost[0]), 32'd0);
        edge_ch(0, 990, 1'b0);
        chk("ch0 one good", 32'(pps_valid[0]), 32'd0);
        edge_ch(0, 6, 1'b0);
        chk("ch0 lower inclusive", 32'(period_meas[0 +: CW]), 32'd990);
        chk("ch0 valid regained", 32'(pps_valid[0]), 32'd1);

        // Stop ch0 edges: lost once cnt reaches 1011.
        run(1008);
        chk("ch0 lost not yet", 32'(pps_lost[0]), 32'd0);
        chk("ch0 valid before lost", 32'(pps_valid[0]), 32'd1);
        run(1);
        chk("ch0 lost", 32'(pps_lost[0]), 32'd1);
        chk("ch0 valid on lost", 32'(pps_valid[0]), 32'd0);
        chk("ch1 untouched count", 32'(pps_count[EW +: EW]), 32'd0);
        chk("ch1 untouched valid", 32'(pps_valid[1]), 32'd0);
        edge_ch(0, 1000, 1'b0);
        chk("ch0 lost cleared", 32'(pps_lost[0]), 32'd0);
        chk("ch0 meas kept", 32'(period_meas[0 +: CW]), 32'd990);

        // ch1 falling-edge select: rising edge must not pulse.
        pps_in[1] = 1'b1;
        run(SS + 1);
        chk("ch1 rise ignored", 32'(pps_pulse[1]), 32'd0);
        run(1);
        chk("ch1 count after rise", 32'(pps_count[EW +: EW]), 32'd0);
        edge_ch(1, 1000, 1'b0);
        edge_ch(1, 1000, 1'b0);
        edge_ch(1, 6, 1'b0);
        chk("ch1 valid", 32'(pps_valid[1]), 32'd1);
        chk("ch1 meas", 32'(period_meas[CW +: CW]), 32'd1000);
        chk("ch0 count independent", 32'(pps_count[0 +: EW]), 32'(exp_cnt[0]));
        chk("ch0 timed out alone", 32'(pps_lost[0]), 32'd1);

        // Reset while ch1 is tracking.
        rst_n = 1'b0;
        #1;
        chk("midreset pps_out", 32'(pps_out), 32'd0);
        chk("midreset count", 32'(pps_count), 32'd0);
        chk("midreset meas", period_meas, 32'd0);
        chk("midreset flags", 32'({period_err, pps_lost, pps_valid}), 32'd0);
        run(2);
        rst_n = 1'b1;
        exp_cnt[0] = '0;
        exp_cnt[1] = '0;
        run(SS + 2);
        chk("post-reset rise ignored", 32'(pps_count[EW +: EW]), 32'd0);
        edge_ch(1, 1000, 1'b0);
        chk("post-reset no meas", 32'(period_meas[CW +: CW]), 32'd0);
        chk("post-reset not valid", 32'(pps_valid[1]), 32'd0);

        // tol >= nom: lower bound floors at 0.
        period_nom = CW'(10);
        period_tol = CW'(20);
        edge_ch(0, 6, 1'b0);
        edge_ch(0, 6, 1'b0);
        edge_ch(0, 6, 1'b0);
        chk("floor lower meas", 32'(period_meas[0 +: CW]), 32'd6);
        chk("floor lower valid", 32'(pps_valid[0]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
